// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered or FWFT read, thresholds, occupancy count and sticky errors
module sync_fifo #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 5,
  parameter bit FWFT          = 1'b0,
  parameter int AFULL_THRESH  = 2**ADDR_WIDTH - 4,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_wr_en,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_rd_en,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_full,
  output logic                  o_empty,
  output logic                  o_almost_full,
  output logic                  o_almost_empty,
  output logic [ADDR_WIDTH:0]   o_count,
  output logic                  o_overflow,
  output logic                  o_underflow
);
  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] af_lvl = AFULL_THRESH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] ae_lvl = AEMPTY_THRESH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] wrap = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] zero = '0;

  if (AEMPTY_THRESH < 0 || AEMPTY_THRESH >= AFULL_THRESH || AFULL_THRESH > DEPTH) begin : g_bad_thresh
    $error("sync_fifo: thresholds must satisfy 0 <= AEMPTY_THRESH < AFULL_THRESH <= DEPTH");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt, count_nxt;
  logic wr_acc, rd_acc;

  assign wr_acc    = i_wr_en & ~o_full;
  assign rd_acc    = i_rd_en & ~o_empty;
  assign wr_nxt    = wr_ptr + {zero[ADDR_WIDTH:1], wr_acc};
  assign rd_nxt    = rd_ptr + {zero[ADDR_WIDTH:1], rd_acc};
  assign count_nxt = o_count + {zero[ADDR_WIDTH:1], wr_acc} - {zero[ADDR_WIDTH:1], rd_acc};

  // storage is left unreset so it maps onto block RAM
  always_ff @(posedge i_clk)
    if (wr_acc) mem[wr_ptr[ADDR_WIDTH-1:0]] <= i_wr_data;

  // pointers, count and all flags advance together from the next-state values
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      o_count        <= '0;
      o_full         <= 1'b0;
      o_empty        <= 1'b1;
      o_almost_full  <= 1'b0;
      o_almost_empty <= 1'b1;
      o_overflow     <= 1'b0;
      o_underflow    <= 1'b0;
    end else begin
      wr_ptr         <= wr_nxt;
      rd_ptr         <= rd_nxt;
      o_count        <= count_nxt;
      o_full         <= (wr_nxt ^ rd_nxt) == wrap;
      o_empty        <= wr_nxt == rd_nxt;
      o_almost_full  <= count_nxt >= af_lvl;
      o_almost_empty <= count_nxt <= ae_lvl;
      o_overflow     <= o_overflow | (i_wr_en & o_full);
      o_underflow    <= o_underflow | (i_rd_en & o_empty);
    end
  end

  if (FWFT) begin : g_fwft
    assign o_rd_data = mem[rd_ptr[ADDR_WIDTH-1:0]];
  end else begin : g_reg
    // registered read: capture the head on each accepted pop, hold otherwise
    always_ff @(posedge i_clk)
      if (i_rst) o_rd_data <= '0;
      else if (rd_acc) o_rd_data <= mem[rd_ptr[ADDR_WIDTH-1:0]];
  end
endmodule

// File: doc/sync_fifo.md
# sync_fifo

Single-clock, parametrised FIFO: successor to the dual-port FIFO memory in the AXI FIFO/DMA path. It wraps storage with its own pointer, flag and occupancy logic. It adds selectable read mode (registered or first-word-fall-through), programmable almost-full/almost-empty thresholds, an occupancy count and sticky overflow/underflow error flags. DMA channel buffers instantiate it between the AXI read engine and the AXI write engine.

## Interface
Parameters:
- DATA_WIDTH, 32, word width in bits (≥1)
- ADDR_WIDTH, 5, log2 of depth; DEPTH = 2**ADDR_WIDTH words
- FWFT, 0, 0 = registered read, 1 = first-word-fall-through
- AFULL_THRESH, DEPTH-4, o_almost_full asserts when count ≥ this
- AEMPTY_THRESH, 4, o_almost_empty asserts when count ≤ this

Ports:
- i_clk  in  1  single clock; all logic is on its rising edge
- i_rst  in  1  reset, synchronous, active-high
- i_wr_en  in  1  write request
- i_wr_data  in  DATA_WIDTH  write data
- i_rd_en  in  1  read/pop request
- o_rd_data  out  DATA_WIDTH  read data
- o_full  out  1  FIFO holds DEPTH words
- o_empty  out  1  FIFO holds 0 words
- o_almost_full  out  1  count ≥ AFULL_THRESH
- o_almost_empty  out  1  count ≤ AEMPTY_THRESH
- o_count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
- o_overflow  out  1  sticky: a write was attempted while full
- o_underflow  out  1  sticky: a read was attempted while empty

## Operation
- Storage: DEPTH×DATA_WIDTH array. It is not reset, so it can be inferred as block RAM.
- Pointers: wr_ptr and rd_ptr are ADDR_WIDTH+1 bits. The low ADDR_WIDTH bits address the array. The MSB is a wrap bit.
  - Empty: the two pointers are equal.
  - Full: the low bits are equal and the MSBs differ.
  - Each pointer wraps naturally from 2*DEPTH-1 to 0.
- Write accept: wr_acc = i_wr_en & ~o_full. The word goes to mem[wr_ptr] and wr_ptr increments.
- Read accept: rd_acc = i_rd_en & ~o_empty. rd_ptr increments.
- Flags use registered state. Acceptance depends only on the flags at that edge, never on the other request in the same cycle.
  - Full with both requests: the read is accepted and the write is rejected (error flagged).
  - Empty with both requests: the write is accepted and the read is rejected (error flagged).
- o_count next value: +1 on wr_acc only, −1 on rd_acc only, unchanged on both or neither.
- o_full, o_empty, o_almost_full and o_almost_empty are registered. Each is computed from the next count, so all flags change on the same edge as o_count.
- Error flags:
  - o_overflow is set when i_wr_en & o_full.
  - o_underflow is set when i_rd_en & o_empty.
  - Both hold until i_rst.
  - Rejected requests never change pointers, count or data.
- FWFT=0: o_rd_data ← mem[rd_ptr] on rd_acc. Otherwise it holds its last value.
- FWFT=1: o_rd_data = mem[rd_ptr] (asynchronous array read) whenever o_empty=0. It is a don't-care while empty. rd_acc pops the head, and the next head appears after that edge.
- Threshold constraints: 0 ≤ AEMPTY_THRESH < AFULL_THRESH ≤ DEPTH. Elaboration-time assertion on violation.

## Timing
- Reset, at the first edge with i_rst=1:
  - o_count=0, o_empty=1, o_almost_empty=1.
  - o_full=0, o_almost_full=0, o_overflow=0, o_underflow=0.
  - o_rd_data=0 (FWFT=0), pointers=0.
- Reset mid-operation discards all contents. An i_wr_en/i_rd_en in the reset cycle is ignored.
- Write-to-empty-deassert latency: 1 cycle. A write at edge N gives o_empty=0 after edge N.
- Read latency:
  - FWFT=0: data is valid in the cycle after the accepting edge.
  - FWFT=1: the head is valid in the same cycle that o_empty=0.
- Full asserts after the edge that accepts the DEPTH-th word. It deasserts after the edge of the first accepted read.
- Throughput: one write and one read per cycle. The count is stable under a continuous simultaneous stream.

## Test plan
- Reset then idle → o_empty=1, o_almost_empty=1, o_count=0, o_rd_data=0, all other flags 0.
- DEPTH=32, write 0..31 then 1 extra → o_full=1 after word 31, o_count=32. The extra write sets o_overflow=1, o_count stays 32, and reading back yields 0..31 in order.
- FWFT=0, write 0xA5 then read → o_rd_data=0xA5 one cycle after the accept. Another read → o_underflow=1, o_rd_data holds 0xA5.
- FWFT=1, write 0x11, 0x22 → o_rd_data=0x11 the cycle after the first write. One pop → o_rd_data=0x22.
- Fill to 16, then simultaneous read+write for 100 cycles with incrementing data → o_count stays 16, no errors, output order intact across pointer wrap.
- Thresholds 28/4: step the count 0→32→0 → o_almost_empty deasserts at count 5, o_almost_full asserts at count 28. Assert i_rst at count 20 → all outputs return to their reset values next cycle.
